// File: rtl/nrzi_tx_ctrl_if.sv
// nrzi_tx_ctrl_if: byte-stream handshake between a payload source and nrzi_tx_ctrl.
//   data_in    : payload byte (source -> controller)
//   data_valid : data_in is valid (source -> controller)
//   data_last  : data_in is the final byte of the frame (source -> controller)
//   data_ready : controller accepts a byte this cycle (controller -> source)
// Modports: master = payload source, slave = controller.
interface nrzi_tx_ctrl_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;

  modport master (
    output data_in,
    output data_valid,
    output data_last,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    input  data_last,
    output data_ready
  );
endinterface

// File: rtl/nrzi_tx_ctrl.sv
// nrzi_tx_ctrl: transmit sequencer feeding the nrzi encoder's x input, one bit per clock.
// A frame is SYNC_BITS sync bits (SYNC_PATTERN, LSB-first), then payload bytes taken over a
// valid/ready handshake (LSB-first), then EOP_BITS trailer zeros.
// Optional feature: define NRZI_TX_BIT_STUFF_EN to insert a 0 after every six consecutive 1s
// in the data section (USB-style bit stuffing).
// Ports:
//   clock      : rising-edge clock, shared with nrzi
//   reset      : asynchronous active-low reset
//   start      : frame request, sampled only in IDLE
//   dbus       : payload handshake (slave modport of nrzi_tx_ctrl_if)
//   x_out      : bit to the encoder's x input
//   bit_en     : x_out carries a frame bit this cycle
//   busy       : frame in progress
//   done       : one-cycle pulse in the first IDLE cycle after a frame
//   err        : one-cycle pulse after an underrun
// All outputs are decoded from registers only.
module nrzi_tx_ctrl #(
  parameter int unsigned SYNC_BITS    = 8,
  parameter logic [15:0] SYNC_PATTERN = 16'h0080,
  parameter int unsigned EOP_BITS     = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  nrzi_tx_ctrl_if.slave  dbus,
  output logic           x_out,
  output logic           bit_en,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSync  = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
`ifdef NRZI_TX_BIT_STUFF_EN
  localparam logic [2:0] StStuff = 3'd3;
`endif
  localparam logic [2:0] StEop   = 3'd4;

  localparam logic [3:0] SyncLast = 4'(SYNC_BITS - 1);
  localparam logic [3:0] EopLast  = 4'(EOP_BITS - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       last_q, last_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       ending;
`ifdef NRZI_TX_BIT_STUFF_EN
  logic [2:0] ones_q, ones_d;
  // Frame ends after the pending stuff bit instead of returning to DATA.
  logic       end_q, end_d;
  logic       stuff;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ending  = 1'b0;
`ifdef NRZI_TX_BIT_STUFF_EN
    ones_d  = ones_q;
    end_d   = end_q;
    stuff   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSync;
          cnt_d   = 4'd0;
          last_d  = 1'b0;
        end
      end
      StSync: begin
        if (cnt_q == SyncLast) begin
          cnt_d = 4'd0;
`ifdef NRZI_TX_BIT_STUFF_EN
          ones_d = 3'd0;
`endif
          if (dbus.data_valid) begin
            shreg_d = dbus.data_in;
            last_d  = dbus.data_last;
            state_d = StData;
          end else begin
            err_d   = 1'b1;
            state_d = StEop;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StData: begin
        shreg_d = {1'b0, shreg_q[7:1]};
        cnt_d   = cnt_q + 4'd1;
`ifdef NRZI_TX_BIT_STUFF_EN
        if (shreg_q[0]) begin
          ones_d = (ones_q == 3'd6) ? 3'd6 : ones_q + 3'd1;
        end else begin
          ones_d = 3'd0;
        end
        stuff = (ones_d == 3'd6);
`endif
        // Bit 7: fetch the next byte, or finish on last byte / underrun.
        if (cnt_q == 4'd7) begin
          cnt_d = 4'd0;
          if (last_q) begin
            ending = 1'b1;
          end else if (dbus.data_valid) begin
            shreg_d = dbus.data_in;
            last_d  = dbus.data_last;
          end else begin
            err_d  = 1'b1;
            ending = 1'b1;
          end
        end
`ifdef NRZI_TX_BIT_STUFF_EN
        if (stuff) begin
          state_d = StStuff;
          end_d   = ending;
        end else if (ending) begin
          state_d = StEop;
        end
`else
        if (ending) begin
          state_d = StEop;
        end
`endif
      end
`ifdef NRZI_TX_BIT_STUFF_EN
      StStuff: begin
        ones_d  = 3'd0;
        state_d = end_q ? StEop : StData;
      end
`endif
      StEop: begin
        if (cnt_q == EopLast) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      shreg_q <= 8'd0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef NRZI_TX_BIT_STUFF_EN
      ones_q  <= 3'd0;
      end_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef NRZI_TX_BIT_STUFF_EN
      ones_q  <= ones_d;
      end_q   <= end_d;
`endif
    end
  end

  assign bit_en = (state_q != StIdle);
  assign busy   = (state_q != StIdle);
  assign x_out  = ((state_q == StSync) && SYNC_PATTERN[cnt_q]) ||
                  ((state_q == StData) && shreg_q[0]);
  assign dbus.data_ready = ((state_q == StSync) && (cnt_q == SyncLast)) ||
                           ((state_q == StData) && (cnt_q == 4'd7) && !last_q);
  assign done = done_q;
  assign err  = err_q;

endmodule
